// File: rtl/sfifo_stream_reader_if.sv
// Stream bundle for sfifo_stream_reader: show-ahead FIFO read side plus the
// registered valid/ready output stream. master = reader, slave = FIFO/consumer side.
interface sfifo_stream_reader_if #(
  parameter int DWIDTH = 64
);
  logic [DWIDTH-1:0] fifo_dout;
  logic              fifo_empty;
  logic              fifo_rd_en;
  logic [DWIDTH-1:0] m_data;
  logic              m_valid;
  logic              m_ready;
  logic              m_last;

  modport master (
    input  fifo_dout, fifo_empty, m_ready,
    output fifo_rd_en, m_data, m_valid, m_last
  );

  modport slave (
    output fifo_dout, fifo_empty, m_ready,
    input  fifo_rd_en, m_data, m_valid, m_last
  );
endinterface

// File: rtl/sfifo_stream_reader.sv
// Drains a show-ahead sfifo into a registered valid/ready stream through a
// 2-entry skid stage. Optional m_last generation under macro FIFO_RDR_LAST_EN.
module sfifo_stream_reader #(
  parameter int DWIDTH  = 64,
  parameter int PKT_LEN = 8,
  parameter int CWIDTH  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  sfifo_stream_reader_if.master bus,
  output logic [CWIDTH-1:0] beat_cnt,
  output logic              idle
);

  if (PKT_LEN < 1) begin : g_bad_pkt_len
    $error("sfifo_stream_reader: PKT_LEN must be >= 1");
  end

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } occ_e;

  occ_e              state, state_next;
  logic [DWIDTH-1:0] head, head_next;
  logic [DWIDTH-1:0] tail, tail_next;
  logic              push;
  logic              pop;
  logic              valid;

  // fifo_rd_en depends only on registered occupancy, never on m_ready.
  assign valid = (state != EMPTY);
  assign push  = rst_n & ~bus.fifo_empty & (state != TWO);
  assign pop   = valid & bus.m_ready;

  // NOTE: every signal assigned in always_comb gets a default first, so no
  // path through the case leaves it unassigned and no latch is inferred.
  always_comb begin
    state_next = state;
    head_next  = head;
    tail_next  = tail;
    unique case (state)
      EMPTY: begin
        if (push) begin
          head_next  = bus.fifo_dout;
          state_next = ONE;
        end
      end
      ONE: begin
        case ({push, pop})
          2'b11: head_next = bus.fifo_dout;
          2'b10: begin
            tail_next  = bus.fifo_dout;
            state_next = TWO;
          end
          2'b01:   state_next = EMPTY;
          default: state_next = ONE;
        endcase
      end
      TWO: begin
        if (pop) begin
          head_next  = tail;
          state_next = ONE;
        end
      end
      default: state_next = EMPTY;
    endcase
  end

  // NOTE: reset is synchronous here, and the data registers are cleared too
  // so m_data reads 0 while in reset rather than stale or X data.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= EMPTY;
      head     <= '0;
      tail     <= '0;
      beat_cnt <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples the pre-edge values regardless of statement order.
      state <= state_next;
      head  <= head_next;
      tail  <= tail_next;
      if (pop) beat_cnt <= beat_cnt + CWIDTH'(1);
    end
  end

  assign bus.fifo_rd_en = push;
  assign bus.m_valid    = valid;
  assign bus.m_data     = head;
  assign idle           = (state == EMPTY) & bus.fifo_empty;

`ifdef FIFO_RDR_LAST_EN
  localparam int PWIDTH = $clog2(PKT_LEN) + 1;
  localparam logic [PWIDTH-1:0] PKT_LAST = PWIDTH'(PKT_LEN - 1);

  logic [PWIDTH-1:0] pkt_cnt;
  logic              last;

  // pkt_cnt only moves on pops, so m_last is stable while the beat is stalled.
  assign last = valid & (pkt_cnt == PKT_LAST);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pkt_cnt <= '0;
    end else if (pop) begin
      pkt_cnt <= last ? '0 : pkt_cnt + PWIDTH'(1);
    end
  end

  assign bus.m_last = last;
`else
  assign bus.m_last = 1'b0;
`endif

endmodule

// File: tb/tb_sfifo_stream_reader.sv
// Self-checking bench for sfifo_stream_reader: FIFO model, expected-order
// queue and handshake monitor; covers m_last when FIFO_RDR_LAST_EN is defined.
module tb_sfifo_stream_reader;
  localparam int DW = 64;
  localparam int PL = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  sfifo_stream_reader_if #(.DWIDTH(DW)) bus ();
  sfifo_stream_reader_if #(.DWIDTH(DW)) bus_w ();

  logic [31:0] beat_cnt;
  logic        idle;
  logic [3:0]  beat_cnt_w;
  logic        idle_w;

  sfifo_stream_reader #(.DWIDTH(DW), .PKT_LEN(PL), .CWIDTH(32)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .beat_cnt (beat_cnt),
    .idle     (idle)
  );

  sfifo_stream_reader #(.DWIDTH(DW), .PKT_LEN(PL), .CWIDTH(4)) dut_w (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus_w),
    .beat_cnt (beat_cnt_w),
    .idle     (idle_w)
  );

  logic [63:0] fq[$];
  logic [63:0] fqw[$];
  logic [63:0] exp_q[$];
  logic        hold_empty;
  int          tests = 0;
  int          fails = 0;
  int          pops  = 0;
  int          lasts = 0;
  logic        stalled = 1'b0;
  logic [63:0] stall_data;
  logic        stall_last;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, expv);
    end
  endtask

  task automatic refresh();
    bus.fifo_empty   = hold_empty || (fq.size() == 0);
    bus.fifo_dout    = (fq.size() != 0) ? fq[0] : '0;
    bus_w.fifo_empty = (fqw.size() == 0);
    bus_w.fifo_dout  = (fqw.size() != 0) ? fqw[0] : '0;
  endtask

  // FIFO model pops its head on every edge where rd_en was high.
  task automatic tick();
    logic take, take_w;
    @(posedge clk);
    take   = bus.fifo_rd_en;
    take_w = bus_w.fifo_rd_en;
    #1;
    if (take && fq.size() != 0) void'(fq.pop_front());
    if (take_w && fqw.size() != 0) void'(fqw.pop_front());
    refresh();
  endtask

  task automatic push_beat(input logic [63:0] d);
    fq.push_back(d);
    exp_q.push_back(d);
    refresh();
  endtask

  // Handshake monitor, sampled mid-cycle.
  always @(negedge clk) begin
    logic el;
    if (rst_n !== 1'b1) begin
      pops    = 0;
      lasts   = 0;
      stalled = 1'b0;
    end else begin
      check("no_pop_when_empty", bus.fifo_rd_en && bus.fifo_empty, 1'b0);
      if (stalled) begin
        check("stall_valid", bus.m_valid, 1'b1);
        check("stall_data", bus.m_data, stall_data);
        check("stall_last", bus.m_last, stall_last);
      end
      if (bus.m_valid) begin
`ifdef FIFO_RDR_LAST_EN
        el = ((pops % PL) == PL - 1);
`else
        el = 1'b0;
`endif
        check("m_last", bus.m_last, el);
      end else begin
        check("m_last_invalid", bus.m_last, 1'b0);
      end
      if (bus.m_valid && bus.m_ready) begin
        if (exp_q.size() == 0) check("extra_beat", 1'b1, 1'b0);
        else check("order", bus.m_data, exp_q.pop_front());
        check("beat_cnt", beat_cnt, pops);
        if (bus.m_last) lasts++;
        pops++;
      end
      stalled    = bus.m_valid && !bus.m_ready;
      stall_data = bus.m_data;
      stall_last = bus.m_last;
    end
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] abcd[4];
    int start, cyc;

    // 1: reset with a non-empty FIFO
    rst_n         = 1'b0;
    hold_empty    = 1'b0;
    bus.m_ready   = 1'b0;
    bus_w.m_ready = 1'b1;
    push_beat(64'hdead_beef);
    repeat (3) tick();
    check("rst_rd_en", bus.fifo_rd_en, 1'b0);
    check("rst_valid", bus.m_valid, 1'b0);
    check("rst_data", bus.m_data, 64'h0);
    check("rst_beat_cnt", beat_cnt, 32'h0);
    check("rst_idle", idle, 1'b0);

    // 2: streaming, preloaded during reset
    fq.delete();
    exp_q.delete();
    for (int i = 1; i <= 16; i++) push_beat(64'(i));
    tick();
    bus.m_ready = 1'b1;
    rst_n       = 1'b1;
    for (int i = 0; i < 16; i++) begin
      tick();
      check("stream_valid", bus.m_valid, 1'b1);
      check("stream_data", bus.m_data, 64'(i + 1));
    end
    tick();
    check("stream_done_valid", bus.m_valid, 1'b0);
    check("stream_beat_cnt", beat_cnt, 32'd16);
    check("stream_idle", idle, 1'b1);

    // 3: backpressure
    bus.m_ready = 1'b0;
    abcd[0] = 64'hA; abcd[1] = 64'hB; abcd[2] = 64'hC; abcd[3] = 64'hD;
    for (int i = 0; i < 4; i++) push_beat(abcd[i]);
    repeat (10) tick();
    check("bp_rd_en", bus.fifo_rd_en, 1'b0);
    check("bp_fifo_left", 64'(fq.size()), 64'd2);
    check("bp_valid", bus.m_valid, 1'b1);
    check("bp_data", bus.m_data, abcd[0]);
    bus.m_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("bp_drain_valid", bus.m_valid, 1'b1);
      check("bp_drain_data", bus.m_data, abcd[i]);
      tick();
    end
    check("bp_end_valid", bus.m_valid, 1'b0);
    check("bp_beat_cnt", beat_cnt, 32'd20);

    // 4: random ready / empty
    start = pops;
    cyc   = 0;
    while ((pops - start) < 10000 && cyc < 60000) begin
      bus.m_ready = ($urandom_range(0, 9) < 7);
      hold_empty  = ($urandom_range(0, 9) < 3);
      while (fq.size() < 3) push_beat({$urandom, $urandom});
      refresh();
      tick();
      cyc++;
    end
    check("rand_budget", (pops - start) >= 10000, 1'b1);
    bus.m_ready = 1'b1;
    hold_empty  = 1'b0;
    refresh();
    cyc = 0;
    while (exp_q.size() != 0 && cyc < 20) begin
      tick();
      cyc++;
    end
    tick();
    check("rand_drained", 64'(exp_q.size()), 64'd0);
    check("rand_beat_cnt", beat_cnt, 32'(pops));
    check("rand_idle", idle, 1'b1);

    // 5: counter wrap on the CWIDTH=4 instance
    for (int i = 1; i <= 18; i++) fqw.push_back(64'(i));
    refresh();
    repeat (22) tick();
    check("wrap_beat_cnt", beat_cnt_w, 4'd2);
    check("wrap_idle", idle_w, 1'b1);

    // 6: packet framing with random stalls
    rst_n = 1'b0;
    fq.delete();
    exp_q.delete();
    refresh();
    repeat (2) tick();
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) push_beat(64'(32'h100 + i));
    cyc = 0;
    while (pops < 12 && cyc < 500) begin
      bus.m_ready = ($urandom_range(0, 1) == 1);
      tick();
      cyc++;
    end
    check("pkt_beats", 64'(pops), 64'd12);
`ifdef FIFO_RDR_LAST_EN
    check("pkt_lasts", 64'(lasts), 64'd3);
`else
    check("pkt_lasts", 64'(lasts), 64'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
